// File: rtl/dsp_pkg.sv
// dsp_pkg: opcodes, status codes and scheduler state encoding shared by the DSP job scheduler.
package dsp_pkg;
  localparam logic [3:0] OP_FFT  = 4'd0;
  localparam logic [3:0] OP_IFFT = 4'd1;
  localparam logic [3:0] OP_FIR  = 4'd2;
  localparam logic [3:0] OP_IIR  = 4'd3;
  localparam logic [3:0] OP_CORR = 4'd4;
  localparam logic [3:0] OP_MAX  = OP_CORR;
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ACC_ERR = 2'b01,
    ST_BAD_OP  = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;
  typedef enum logic [2:0] {
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_RESPOND,
    S_COOL
  } state_e;
  function automatic logic op_is_valid(input logic [3:0] op);
    return op <= OP_MAX;
  endfunction
endpackage

// File: rtl/dsp_job_scheduler_if.sv
// dsp_job_scheduler_if: requester and accelerator handshake signals of the DSP job scheduler.
interface dsp_job_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int SELW    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [1:0]           resp_status;
  logic                 acc_enable;
  logic [3:0]           acc_operation;
  logic [SELW-1:0]      acc_sel;
  logic                 acc_done;
  logic                 acc_error;
  modport master (
    output req_valid, req_op, acc_done, acc_error,
    input  req_ready, resp_valid, resp_status, acc_enable, acc_operation, acc_sel
  );
  modport slave (
    input  req_valid, req_op, acc_done, acc_error,
    output req_ready, resp_valid, resp_status, acc_enable, acc_operation, acc_sel
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search of req_i starting at ptr_i, ascending with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SELW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SELW-1:0]    ptr_i,
  output logic [SELW-1:0]    idx_o,
  output logic               hit_o
);
  logic [SELW-1:0] cand;
  // Scan farthest-first so the candidate closest to the pointer is written last and wins.
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = SELW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        idx_o = cand;
        hit_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dsp_job_scheduler.sv
// dsp_job_scheduler: round-robin grant of the DSP accelerator with issue/wait/respond sequencing and a watchdog.
module dsp_job_scheduler
  import dsp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int SELW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dsp_job_scheduler_if.slave   bus,
  output logic                 busy,
  output logic                 fault,
  output logic [15:0]          job_count
);
  localparam int              WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [SELW-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, grant_idx;
  logic                grant_hit;
  logic [3:0]          op_q, op_d, grant_op;
  logic [WDW-1:0]      wdog_q, wdog_d;
  status_e             status_q, status_d;
  logic                fault_q, fault_d;
  logic [15:0]         job_count_q, job_count_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic                acc_enable_q, acc_enable_d, busy_q, busy_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .SELW(SELW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .idx_o (grant_idx),
    .hit_o (grant_hit)
  );

  assign grant_op = bus.req_op[{grant_idx, 2'b00} +: 4];

  // Every output is a register loaded from the next state, so it appears in the cycle the state is entered.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    wdog_d      = wdog_q;
    status_d    = status_q;
    fault_d     = fault_q;
    req_ready_d = '0;
    case (state_q)
      S_ARB: if (grant_hit) begin
        owner_d     = grant_idx;
        rr_ptr_d    = (grant_idx == SELW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        req_ready_d = NUM_REQ'(1) << grant_idx;
        if (op_is_valid(grant_op)) begin
          op_d    = grant_op;
          state_d = S_ISSUE;
        end else begin
          status_d = ST_BAD_OP;
          state_d  = S_RESPOND;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (bus.acc_error) begin
        status_d = ST_ACC_ERR;
        state_d  = S_RESPOND;
      end else if (bus.acc_done) begin
        status_d = ST_OK;
        state_d  = S_RESPOND;
      end else if (wdog_q == WD_LAST) begin
        status_d = ST_TIMEOUT;
        fault_d  = 1'b1;
        state_d  = S_RESPOND;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
      S_RESPOND: state_d = S_COOL;
      S_COOL:    state_d = S_ARB;
      default:   state_d = S_ARB;
    endcase
    acc_enable_d = state_d == S_ISSUE;
    busy_d       = state_d != S_ARB;
    resp_valid_d = (state_d == S_RESPOND) ? (NUM_REQ'(1) << owner_d) : '0;
    job_count_d  = job_count_q + 16'(state_d == S_RESPOND);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= S_ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      op_q         <= '0;
      wdog_q       <= '0;
      status_q     <= ST_OK;
      fault_q      <= 1'b0;
      job_count_q  <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      acc_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      wdog_q       <= wdog_d;
      status_q     <= status_d;
      fault_q      <= fault_d;
      job_count_q  <= job_count_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      acc_enable_q <= acc_enable_d;
      busy_q       <= busy_d;
    end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_status   = status_q;
  assign bus.acc_enable    = acc_enable_q;
  assign bus.acc_operation = op_q;
  assign bus.acc_sel       = owner_q;
  assign busy              = busy_q;
  assign fault             = fault_q;
  assign job_count         = job_count_q;
endmodule

// File: tb/tb_dsp_job_scheduler.sv
// tb_dsp_job_scheduler: directed and randomized jobs checked against a job-level timing/status model.
module tb_dsp_job_scheduler;
  import dsp_pkg::*;
  localparam int N  = 4;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, fault;
  logic [15:0] job_count;
  int          total = 0, bad = 0, cyc = 0, n_en = 0, n_resp = 0;
  int          m_ptr = 0, m_en = 0, m_resp = 0;
  logic [15:0] m_cnt = '0;
  logic        m_fault = 1'b0;
  logic [3:0]  m_op = '0;

  always #5 clk = ~clk;

  dsp_job_scheduler_if #(.NUM_REQ(N), .SELW(2)) bus ();

  dsp_job_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .fault     (fault),
    .job_count (job_count)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.acc_enable) n_en <= n_en + 1;
    if (|bus.resp_valid) n_resp <= n_resp + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  // mode: 0 done, 1 error+done, 2 error alone, 3 no answer (timeout). Starts and ends at an ARB negedge.
  task automatic run_job(input logic [N-1:0] mask, input logic [4*N-1:0] ops, input int lat,
                         input int mode, input bit keep, output int en_cyc);
    int w;
    logic [3:0] op;
    bus.req_valid = mask;
    bus.req_op    = ops;
    w     = rr_pick(mask, m_ptr);
    m_ptr = (w + 1) % N;
    op    = ops[4*w +: 4];
    step();
    en_cyc = cyc;
    check("ready", bus.req_ready, 32'(1) << w);
    check("busy", busy, 1);
    if (!keep) bus.req_valid = '0;
    if (op > 4) begin
      m_cnt++;
      m_resp++;
      check("bad_en", bus.acc_enable, 0);
      check("bad_resp", bus.resp_valid, 32'(1) << w);
      check("bad_status", bus.resp_status, ST_BAD_OP);
      check("bad_count", job_count, m_cnt);
    end else begin
      m_en++;
      m_op = op;
      check("enable", bus.acc_enable, 1);
      check("op", bus.acc_operation, op);
      check("sel", bus.acc_sel, w);
      check("early_resp", bus.resp_valid, 0);
      if (mode == 3) step(TO + 1);
      else begin
        step(lat);
        bus.acc_done  = (mode != 2);
        bus.acc_error = (mode != 0);
        step();
        bus.acc_done  = 1'b0;
        bus.acc_error = 1'b0;
      end
      m_cnt++;
      m_resp++;
      if (mode == 3) m_fault = 1'b1;
      check("resp", bus.resp_valid, 32'(1) << w);
      check("status", bus.resp_status, mode == 0 ? ST_OK : mode == 3 ? ST_TIMEOUT : ST_ACC_ERR);
      check("count", job_count, m_cnt);
      check("fault", fault, m_fault);
      check("sel_hold", bus.acc_sel, w);
    end
    step();
    check("cool_busy", busy, 1);
    check("cool_resp", bus.resp_valid, 0);
    step();
    check("arb_busy", busy, 0);
    check("op_hold", bus.acc_operation, m_op);
  endtask

  initial begin
    int e, prev, mode;
    logic [4*N-1:0] ops;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.acc_done  = 1'b0;
    bus.acc_error = 1'b0;
    step(2);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_count", job_count, 0);
    check("rst_enable", bus.acc_enable, 0);
    check("rst_op", bus.acc_operation, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_resp", bus.resp_valid, 0);
    rst_n = 1'b1;
    step();
    run_job(4'b0001, 16'h0002, 18, 0, 0, e);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_job(4'b1111, 16'h4444, 5, 0, 1, e);
      if (i > 0) check("rr_gap", e - prev, 9);
      prev = e;
    end
    run_job(4'b0100, 16'h0700, 0, 0, 0, e);
    run_job(4'b0010, 16'h0030, 7, 1, 0, e);
    bus.acc_done  = 1'b1;
    bus.acc_error = 1'b1;
    step();
    bus.acc_done  = 1'b0;
    bus.acc_error = 1'b0;
    step(3);
    check("spurious_busy", busy, 0);
    check("spurious_count", job_count, m_cnt);
    #1 check("spurious_nresp", n_resp, m_resp);
    run_job(4'b1000, 16'h1000, 0, 3, 0, e);
    run_job(4'b1000, 16'h0000, 3, 0, 0, e);
    repeat (25) begin
      for (int k = 0; k < N; k++) ops[4*k +: 4] = 4'($urandom_range(0, 6));
      mode = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      run_job(N'($urandom_range(1, 15)), ops, int'($urandom_range(1, 20)), mode, 1'($urandom_range(0, 1)), e);
    end
    #1;
    check("n_enable", n_en, m_en);
    check("n_resp", n_resp, m_resp);
    bus.req_valid = 4'b0001;
    bus.req_op    = 16'h0001;
    step();
    m_en++;
    check("pre_rst_enable", bus.acc_enable, 1);
    bus.req_valid = '0;
    step(4);
    check("pre_rst_fault", fault, m_fault);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_fault", fault, 0);
    check("arst_count", job_count, 0);
    check("arst_enable", bus.acc_enable, 0);
    check("arst_op", bus.acc_operation, 0);
    check("arst_sel", bus.acc_sel, 0);
    check("arst_status", bus.resp_status, 0);
    check("arst_ready", bus.req_ready, 0);
    check("arst_resp", bus.resp_valid, 0);
    m_ptr = 0; m_cnt = '0; m_fault = 1'b0; m_op = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
    #1 check("post_rst_nresp", n_resp, m_resp);
    run_job(4'b1111, 16'h2222, 4, 0, 0, e);
    #1;
    check("final_enable", n_en, m_en);
    check("final_resp", n_resp, m_resp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsp_job_scheduler.md
# dsp_job_scheduler

Arbitration and sequencing front-end for the DSP accelerator. Accepts DSP job requests (FFT, IFFT, FIR, IIR, correlate) from up to `NUM_REQ` requesters (CPU cores, DMA), grants the single accelerator round-robin, drives its enable/operation handshake, waits for completion with a watchdog, and returns a per-requester status pulse. The data buses (`data_in`, `coeff`, `data_out`) stay outside this block; an external mux uses `acc_sel`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 256: max WAIT cycles before timeout, ≥ 32.
- `SELW`, default `$clog2(NUM_REQ)`: owner index width.

- `clk`  in  1  clock; everything on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester; held until `req_ready`.
- `req_op`  in  4*NUM_REQ  opcode of requester i at bits [4i+3:4i]; stable while `req_valid[i]`.
- `req_ready`  out  NUM_REQ  one-cycle accept pulse to granted requester.
- `resp_valid`  out  NUM_REQ  one-cycle completion pulse to owner.
- `resp_status`  out  2  00 ok, 01 accelerator error, 10 bad opcode, 11 timeout; valid with any `resp_valid` bit.
- `acc_enable`  out  1  one-cycle start pulse to accelerator.
- `acc_operation`  out  4  opcode to accelerator.
- `acc_sel`  out  SELW  current owner, for data mux.
- `acc_done`  in  1  accelerator done pulse.
- `acc_error`  in  1  accelerator error pulse.
- `busy`  out  1  high in every state except ARB.
- `fault`  out  1  sticky after a timeout; cleared only by reset.
- `job_count`  out  16  completed jobs, any status, wraps.

## Operation
- States: ARB, ISSUE, WAIT, RESPOND, COOL. Reset state is ARB.
- **ARB**
  - Search `req_valid` starting at pointer `rr_ptr` (reset 0), ascending with wrap.
  - On a hit i: latch `owner=i` and `op=req_op[i]`, set `rr_ptr=(i+1) mod NUM_REQ`, pulse `req_ready[i]` next cycle.
  - Valid opcodes are 0..4. Valid opcode: go to ISSUE. Opcode ≥ 5: go to RESPOND with status 10, and the accelerator is never touched.
  - No request: stay in ARB.
- **ISSUE** (one cycle): `acc_enable=1`, `acc_operation=op`; go to WAIT and clear the watchdog.
- **WAIT**
  - `acc_error` (alone or together with `acc_done`): status 01.
  - `acc_done` alone: status 00.
  - Watchdog reaches `TIMEOUT-1` with neither: status 11 and set `fault`.
  - Any of the three moves to RESPOND.
- **RESPOND** (one cycle): `resp_valid[owner]=1`, `resp_status` driven, `job_count++`; go to COOL.
- **COOL** (one cycle): required because the accelerator spends one cycle in its own DONE state before re-accepting `enable`. Go to ARB.
- `acc_done`/`acc_error` outside WAIT are ignored.
- `acc_sel` holds the owner from ISSUE through COOL.
- `acc_operation` holds its value after ISSUE. It is 0 at reset.
- Requesters that drop `req_valid` before being granted are simply skipped.
- Reset mid-job: back to ARB, nothing pending, no response issued. The system resets the accelerator on the same reset.
- Reset values: all outputs 0, `rr_ptr=0`, watchdog 0, `fault=0`, `job_count=0`.

## Timing
- All outputs are registered.
- Request sampled in ARB at edge T:
  - `req_ready` and `acc_enable` high in cycle T+1 (ISSUE).
  - WAIT from T+2.
- Done sampled at edge D in WAIT: `resp_valid` in D+1, COOL in D+2, ARB in D+3.
- Next grant no earlier than D+3 sample. Minimum back-to-back job spacing is accelerator latency + 4 cycles.
- Bad opcode sampled at T: `req_ready` and `resp_valid` (status 10) both in T+1, COOL in T+2, ARB in T+3.
- Timeout: RESPOND exactly `TIMEOUT` cycles after entering WAIT.

## Structure
- Shared package `dsp_pkg`:
  - Opcode constants `OP_FFT`=0, `OP_IFFT`=1, `OP_FIR`=2, `OP_IIR`=3, `OP_CORR`=4, `OP_MAX`=4.
  - Status codes `ST_OK`, `ST_ACC_ERR`, `ST_BAD_OP`, `ST_TIMEOUT`.
  - Scheduler state encoding.
- Sub-module `rr_arbiter`: combinational priority-from-pointer search over `NUM_REQ` bits. Outputs a grant index and a hit flag; the pointer register lives in the parent.

## Test plan
- Single FIR job: req0 op=2, accelerator model returns `acc_done` 18 cycles after enable. Expect one `acc_enable` pulse with op 2, then `resp_valid[0]` with status 00 and `job_count=1`.
- Round-robin: req0..3 all held, each op=4, done after 5 cycles. Expect grant order 0,1,2,3,0 with no requester granted twice in a row, and enable pulses ≥ 9 cycles apart.
- Bad opcode: req2 op=7. Expect `req_ready[2]` and `resp_valid[2]` with status 10 in the same cycle, zero `acc_enable` pulses, and `busy` low 3 cycles later.
- Accelerator error: op=3, model pulses `acc_error` and `acc_done` together. Expect status 01. Spurious `acc_done` while in ARB produces no response.
- Timeout: `TIMEOUT`=32, no done. Expect status 11 exactly 32 cycles after WAIT entry and `fault`=1. The next job still completes with status 00.
- Reset mid-WAIT: assert `rst_n`=0 asynchronously. Expect all outputs 0 immediately, no `resp_valid`, and `rr_ptr`=0 so req0 wins the first post-reset grant.
